mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the fetch stage (instruction reads) and the load/store stage (data reads and writes).
- Accepts one transaction at a time and tracks its owner.
- Routes the response back to that owner.
- Data port has default priority; a starvation counter guarantees fetch forward progress. Fetch redirects can discard an in-flight instruction response.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between instruction fetch and load/store, routing each response to its owner.
// Latency: grant and mem request are combinational in IDLE; the response is forwarded combinationally in the cycle it arrives.
// Backpressure: one transaction outstanding; readies are 0 while BUSY. Build with MEM_ARB_RR_EN for round-robin tie-break.
module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid_i,
  input  logic [AWIDTH-1:0]   if_req_addr_i,
  output logic                if_req_ready_o,
  input  logic                if_flush_i,
  output logic                if_rsp_valid_o,
  output logic [DWIDTH-1:0]   if_rsp_data_o,
  input  logic                d_req_valid_i,
  input  logic                d_req_we_i,
  input  logic [AWIDTH-1:0]   d_req_addr_i,
  input  logic [DWIDTH-1:0]   d_req_wdata_i,
  input  logic [DWIDTH/8-1:0] d_req_be_i,
  output logic                d_req_ready_o,
  output logic                d_rsp_valid_o,
  output logic [DWIDTH-1:0]   d_rsp_data_o,
  output logic                mem_valid_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DWIDTH-1:0]   mem_rsp_data_i
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_DATA = 2'd2} owner_t;

  state_t r_state, w_state_nxt;
  owner_t r_owner, w_owner_nxt;
  logic   r_squash, w_squash_nxt;
  logic   r_store, w_store_nxt;   // outstanding data transaction is a store
  logic   w_fetch_wins;           // tie-break result when both ports request
  logic   w_grant_f, w_grant_d;

`ifdef MEM_ARB_RR_EN
  logic r_last_fetch, w_last_fetch_nxt;

  // Round-robin: on a tie the port not granted last time wins
  always_comb w_fetch_wins = !r_last_fetch;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] r_starve_cnt, w_starve_cnt_nxt;

  // Data priority, except fetch is forced once it has lost STARVE_MAX ties in a row
  always_comb w_fetch_wins = (r_starve_cnt == STARVE_LIM);
`endif

  // Next-state, grant selection and output routing
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_squash_nxt   = r_squash;
    w_store_nxt    = r_store;
`ifdef MEM_ARB_RR_EN
    w_last_fetch_nxt = r_last_fetch;
`else
    w_starve_cnt_nxt = r_starve_cnt;
`endif
    w_grant_f      = 1'b0;
    w_grant_d      = 1'b0;
    if_req_ready_o = 1'b0;
    d_req_ready_o  = 1'b0;
    if_rsp_valid_o = 1'b0;
    if_rsp_data_o  = '0;
    d_rsp_valid_o  = 1'b0;
    d_rsp_data_o   = '0;
    mem_valid_o    = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_be_o       = '0;
    // Everything stays quiet during the reset cycle
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          w_grant_f = if_req_valid_i && (!d_req_valid_i || w_fetch_wins);
          w_grant_d = d_req_valid_i && !w_grant_f;
          if (w_grant_f) begin
            if_req_ready_o = 1'b1;
            mem_valid_o    = 1'b1;
            mem_addr_o     = if_req_addr_i;
            mem_be_o       = '1;
            w_state_nxt    = ST_BUSY;
            w_owner_nxt    = OWN_FETCH;
`ifdef MEM_ARB_RR_EN
            w_last_fetch_nxt = 1'b1;
`else
            w_starve_cnt_nxt = 4'd0;
`endif
          end else if (w_grant_d) begin
            d_req_ready_o = 1'b1;
            mem_valid_o   = 1'b1;
            mem_we_o      = d_req_we_i;
            mem_addr_o    = d_req_addr_i;
            mem_wdata_o   = d_req_wdata_i;
            mem_be_o      = d_req_be_i;
            w_state_nxt   = ST_BUSY;
            w_owner_nxt   = OWN_DATA;
            w_store_nxt   = d_req_we_i;
`ifdef MEM_ARB_RR_EN
            w_last_fetch_nxt = 1'b0;
`else
            if (if_req_valid_i)
              w_starve_cnt_nxt = (r_starve_cnt == STARVE_LIM) ? STARVE_LIM : r_starve_cnt + 4'd1;
            else
              w_starve_cnt_nxt = 4'd0;
`endif
          end
        end
        ST_BUSY: begin
          if (mem_rsp_valid_i) begin
            w_state_nxt  = ST_IDLE;
            w_owner_nxt  = OWN_NONE;
            w_squash_nxt = 1'b0;
            // A redirect (earlier or in this very cycle) makes the instruction stale
            if (r_owner == OWN_FETCH) begin
              if (!r_squash && !if_flush_i) begin
                if_rsp_valid_o = 1'b1;
                if_rsp_data_o  = mem_rsp_data_i;
              end
            end else if (r_owner == OWN_DATA) begin
              d_rsp_valid_o = 1'b1;
              d_rsp_data_o  = r_store ? '0 : mem_rsp_data_i;
            end
          end else if (if_flush_i && r_owner == OWN_FETCH) begin
            w_squash_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_NONE;
      r_squash <= 1'b0;
      r_store  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_fetch <= 1'b1;
`else
      r_starve_cnt <= 4'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_squash <= w_squash_nxt;
      r_store  <= w_store_nxt;
`ifdef MEM_ARB_RR_EN
      r_last_fetch <= w_last_fetch_nxt;
`else
      r_starve_cnt <= w_starve_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid_i, if_req_ready_o, if_flush_i, if_rsp_valid_o;
  logic [AW-1:0] if_req_addr_i;
  logic [DW-1:0] if_rsp_data_o;
  logic          d_req_valid_i, d_req_we_i, d_req_ready_o, d_rsp_valid_o;
  logic [AW-1:0] d_req_addr_i;
  logic [DW-1:0] d_req_wdata_i, d_rsp_data_o;
  logic [3:0]    d_req_be_i;
  logic          mem_valid_o, mem_we_o, mem_rsp_valid_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rsp_data_i;
  logic [3:0]    mem_be_o;

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i), .if_req_ready_o(if_req_ready_o),
    .if_flush_i(if_flush_i), .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
    .d_req_valid_i(d_req_valid_i), .d_req_we_i(d_req_we_i), .d_req_addr_i(d_req_addr_i),
    .d_req_wdata_i(d_req_wdata_i), .d_req_be_i(d_req_be_i), .d_req_ready_o(d_req_ready_o),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_data_o(d_rsp_data_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a transaction outstanding, who owns it, is it stale
  bit  m_busy = 0;
  int  m_owner = 0;          // 0 none, 1 fetch, 2 data
  bit  m_store = 0;
  bit  m_squash = 0;
  int  m_starve = 0;         // data wins in a row while fetch was waiting
  bit  m_last_fetch = 1;     // most recent grant went to fetch
  byte g_grant;              // "F", "D" or "-" for the last simulated cycle

  // Outputs as sampled in the last simulated cycle
  logic          s_if_rdy, s_d_rdy, s_mv, s_we, s_if_rv, s_d_rv;
  logic [31:0]   s_addr, s_if_rd, s_d_rd;
  logic [3:0]    s_be;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; compare at negedge, then advance the model
  task automatic cycle();
    logic        e_if_rdy, e_d_rdy, e_mv, e_we, e_if_rv, e_d_rv;
    logic [31:0] e_addr, e_wdata, e_if_rd, e_d_rd;
    logic [3:0]  e_be;
    bit          fetch_turn;
    @(negedge clk);
    {e_if_rdy, e_d_rdy, e_mv, e_we, e_if_rv, e_d_rv} = '0;
    e_addr = '0; e_wdata = '0; e_if_rd = '0; e_d_rd = '0; e_be = '0;
    g_grant = "-";
    if (!rst) begin
      if (!m_busy) begin
        if (if_req_valid_i && d_req_valid_i) begin
`ifdef MEM_ARB_RR_EN
          fetch_turn = !m_last_fetch;
`else
          fetch_turn = (m_starve >= SMAX);
`endif
        end else begin
          fetch_turn = if_req_valid_i;
        end
        if (if_req_valid_i && fetch_turn) begin
          g_grant = "F"; e_if_rdy = 1; e_mv = 1; e_addr = if_req_addr_i; e_be = 4'hF;
        end else if (d_req_valid_i) begin
          g_grant = "D"; e_d_rdy = 1; e_mv = 1; e_we = d_req_we_i; e_addr = d_req_addr_i;
          e_wdata = d_req_wdata_i; e_be = d_req_be_i;
        end
      end else if (mem_rsp_valid_i) begin
        if (m_owner == 1) begin
          if (!m_squash && !if_flush_i) begin e_if_rv = 1; e_if_rd = mem_rsp_data_i; end
        end else if (m_owner == 2) begin
          e_d_rv = 1; e_d_rd = m_store ? 32'h0 : mem_rsp_data_i;
        end
      end
    end
    s_if_rdy = if_req_ready_o; s_d_rdy = d_req_ready_o; s_mv = mem_valid_o; s_we = mem_we_o;
    s_addr = mem_addr_o; s_be = mem_be_o; s_if_rv = if_rsp_valid_o; s_if_rd = if_rsp_data_o;
    s_d_rv = d_rsp_valid_o; s_d_rd = d_rsp_data_o;
    check("if_req_ready", if_req_ready_o, e_if_rdy);
    check("d_req_ready", d_req_ready_o, e_d_rdy);
    check("mem_valid", mem_valid_o, e_mv);
    check("if_rsp_valid", if_rsp_valid_o, e_if_rv);
    check("if_rsp_data", if_rsp_data_o, e_if_rd);
    check("d_rsp_valid", d_rsp_valid_o, e_d_rv);
    check("d_rsp_data", d_rsp_data_o, e_d_rd);
    if (rst || e_mv) begin
      check("mem_we", mem_we_o, e_we);
      check("mem_addr", mem_addr_o, e_addr);
      check("mem_be", mem_be_o, e_be);
    end
    if (rst || g_grant == "D") check("mem_wdata", mem_wdata_o, e_wdata);
    // Advance the model
    if (rst) begin
      m_busy = 0; m_owner = 0; m_squash = 0; m_starve = 0; m_last_fetch = 1;
    end else if (!m_busy) begin
      if (g_grant == "F") begin
        m_busy = 1; m_owner = 1; m_starve = 0; m_last_fetch = 1;
      end else if (g_grant == "D") begin
        m_busy = 1; m_owner = 2; m_store = d_req_we_i; m_last_fetch = 0;
        if (if_req_valid_i) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
      end
    end else if (mem_rsp_valid_i) begin
      m_busy = 0; m_owner = 0; m_squash = 0;
    end else if (if_flush_i && m_owner == 1) begin
      m_squash = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    string seq;
    string exp_seq;
    bit    pend;
    int    cnt;

    // Reset with every input active: all outputs must stay 0
    rst = 1; if_req_valid_i = 1; if_req_addr_i = 32'h0100; if_flush_i = 0;
    d_req_valid_i = 1; d_req_we_i = 1; d_req_addr_i = 32'h1234; d_req_wdata_i = 32'hFFFF_FFFF;
    d_req_be_i = 4'hF; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hFFFF_FFFF;
    cycle();
    check("reset_quiet", {s_if_rdy, s_d_rdy, s_mv, s_if_rv, s_d_rv}, 5'b0);
    cycle();

    // Fetch only, latency 1
    rst = 0; d_req_valid_i = 0; mem_rsp_valid_i = 0;
    cycle();
    check("fetch_grant_ready", s_if_rdy, 1'b1);
    check("fetch_grant_addr", s_addr, 32'h0100);
    if_req_valid_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h0000_0013;
    cycle();
    check("fetch_rsp_valid", s_if_rv, 1'b1);
    check("fetch_rsp_data", s_if_rd, 32'h0000_0013);
    mem_rsp_valid_i = 0;

    // Both ports request continuously, latency 1
    seq = "";
    if_req_valid_i = 1; if_req_addr_i = 32'h0300;
    d_req_valid_i = 1; d_req_we_i = 0; d_req_addr_i = 32'h4000;
    for (int k = 0; k < 10; k++) begin
      mem_rsp_valid_i = 0;
      cycle();
      seq = $sformatf("%s%c", seq, g_grant);
      mem_rsp_valid_i = 1; mem_rsp_data_i = $urandom;
      cycle();
    end
`ifdef MEM_ARB_RR_EN
    exp_seq = "DFDFDFDFDF";
`else
    exp_seq = "DDDDFDDDDF";
`endif
    checks++;
    assert (seq == exp_seq) else begin
      errors++;
      $error("FAIL grant_sequence: observed %s expected %s", seq, exp_seq);
    end
    if_req_valid_i = 0; d_req_valid_i = 0; mem_rsp_valid_i = 0;

    // Store with partial byte enables
    d_req_valid_i = 1; d_req_we_i = 1; d_req_addr_i = 32'h2000;
    d_req_wdata_i = 32'hDEAD_BEEF; d_req_be_i = 4'b0011;
    cycle();
    check("store_we", s_we, 1'b1);
    check("store_be", s_be, 4'b0011);
    d_req_valid_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hA5A5_A5A5;
    cycle();
    check("store_ack_valid", s_d_rv, 1'b1);
    check("store_ack_data", s_d_rd, 32'h0);
    mem_rsp_valid_i = 0;

    // Flush while the fetch is outstanding, memory answers 3 cycles after grant
    if_req_valid_i = 1; if_req_addr_i = 32'h0400;
    cycle();
    if_req_valid_i = 0; if_flush_i = 1;
    cycle();
    if_flush_i = 0;
    cycle();
    mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h1111_1111;
    cycle();
    check("flushed_rsp_dropped", s_if_rv, 1'b0);
    mem_rsp_valid_i = 0;
    if_req_valid_i = 1; if_req_addr_i = 32'h0104;
    cycle();
    check("post_flush_grant", s_if_rdy, 1'b1);
    if_req_valid_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h0010_0093;
    cycle();
    check("post_flush_rsp", s_if_rv, 1'b1);
    check("post_flush_data", s_if_rd, 32'h0010_0093);

    // Flush in the same cycle as the response; flush in IDLE does not block a grant
    mem_rsp_valid_i = 0; if_req_valid_i = 1; if_req_addr_i = 32'h0500;
    cycle();
    if_req_valid_i = 0; if_flush_i = 1; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h2222_2222;
    cycle();
    check("same_cycle_flush_drop", s_if_rv, 1'b0);
    mem_rsp_valid_i = 0; if_req_valid_i = 1; if_req_addr_i = 32'h0600;
    cycle();
    check("idle_flush_grant", s_if_rdy, 1'b1);
    if_flush_i = 0; if_req_valid_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h3333_3333;
    cycle();
    check("idle_flush_rsp", s_if_rv, 1'b1);
    mem_rsp_valid_i = 0;

    // Reset while BUSY; late response is ignored and a new data request is granted
    d_req_valid_i = 1; d_req_we_i = 0; d_req_addr_i = 32'h5000;
    cycle();
    d_req_valid_i = 0; rst = 1;
    cycle();
    rst = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h4444_4444;
    d_req_valid_i = 1; d_req_addr_i = 32'h5004;
    cycle();
    check("abandoned_rsp_d", s_d_rv, 1'b0);
    check("abandoned_rsp_if", s_if_rv, 1'b0);
    check("after_reset_grant", s_d_rdy, 1'b1);
    d_req_valid_i = 0; mem_rsp_data_i = 32'h5555_5555;
    cycle();
    check("after_reset_load", s_d_rd, 32'h5555_5555);
    mem_rsp_valid_i = 0;

    // Simultaneous fetch and load with no starvation history
    if_req_valid_i = 1; if_req_addr_i = 32'h0200;
    d_req_valid_i = 1; d_req_we_i = 0; d_req_addr_i = 32'h3000;
    cycle();
`ifndef MEM_ARB_RR_EN
    check("tie_data_first", s_addr, 32'h3000);
`endif
    if (g_grant == "D") d_req_valid_i = 0; else if_req_valid_i = 0;
    mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h6666_6666;
    cycle();
    mem_rsp_valid_i = 0;
    cycle();
`ifndef MEM_ARB_RR_EN
    check("tie_fetch_next", s_addr, 32'h0200);
`endif
    if_req_valid_i = 0; d_req_valid_i = 0; mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h7777_7777;
    cycle();
    mem_rsp_valid_i = 0;

    // Randomized traffic: random latency 1..3, random flushes, occasional stray responses
    pend = 0; cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!if_req_valid_i && $urandom_range(0, 1) == 1) begin
        if_req_valid_i = 1; if_req_addr_i = $urandom;
      end
      if (!d_req_valid_i && $urandom_range(0, 1) == 1) begin
        d_req_valid_i = 1; d_req_we_i = $urandom_range(0, 1); d_req_addr_i = $urandom;
        d_req_wdata_i = $urandom; d_req_be_i = 4'($urandom_range(0, 15));
      end
      if_flush_i = ($urandom_range(0, 7) == 0);
      mem_rsp_data_i = $urandom;
      if (pend) mem_rsp_valid_i = (cnt == 0);
      else mem_rsp_valid_i = ($urandom_range(0, 15) == 0);
      cycle();
      if (pend) begin
        if (mem_rsp_valid_i) pend = 0;
        else cnt--;
      end
      if (g_grant == "F") if_req_valid_i = 0;
      if (g_grant == "D") d_req_valid_i = 0;
      if (g_grant != "-") begin
        pend = 1; cnt = $urandom_range(0, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
